// File: rtl/palindrome_mirror_pkg.sv
// Shared types and defaults for the palindrome mirror writer.
package palindrome_mirror_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/palindrome_mirror_regfile.sv
// Register file owned by the mirror writer: one synchronous write port and
// two asynchronous read ports (copy source and external inspection).
module mirror_regfile #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  output logic [WIDTH-1:0]  rdata_a_o,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [WIDTH-1:0]  rdata_b_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port: the parent decides who owns it on each edge.
  // NOTE: storage is deliberately left without reset; contents must survive a
  // control reset, and a resettable array would cost a flop-level clear.
  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/palindrome_mirror.sv
// Mirror writer: copies r[base+i] onto r[ending-i] until the front and back
// pointers meet, turning the range into a palindrome.
module palindrome_mirror
  import palindrome_mirror_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              go,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] ending,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [WIDTH-1:0]  ext_wdata,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] copies
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] front_q, front_d;
  logic [ADDR_W-1:0] back_q,  back_d;
  logic [ADDR_W-1:0] copies_q, copies_d;

  logic              copy_active;
  logic [WIDTH-1:0]  front_data;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [WIDTH-1:0]  rf_wdata;

  // Pointers have not yet crossed: this edge performs one copy.
  assign copy_active = (state_q == BUSY) && (front_q < back_q);

  // State, pointer and counter registers; reset clears control state only.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      front_q  <= '0;
      back_q   <= '0;
      copies_q <= '0;
    end else begin
      state_q  <= state_d;
      front_q  <= front_d;
      back_q   <= back_d;
      copies_q <= copies_d;
    end
  end

  // Next-state logic for the control FSM.
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (go) state_d = BUSY;
      BUSY:    if (!(front_q < back_q)) state_d = DONE;
      DONE:    if (!go) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pointer and copy-counter updates: load on start, step on every copy.
  always_comb begin
    front_d  = front_q;
    back_d   = back_q;
    copies_d = copies_q;
    if (state_q == IDLE && go) begin
      front_d  = base;
      back_d   = ending;
      copies_d = '0;
    end else if (copy_active) begin
      front_d  = front_q + 1'b1;
      back_d   = back_q - 1'b1;
      copies_d = copies_q + 1'b1;
    end
  end

  // Moore outputs decoded from state alone.
  always_comb begin
    busy = (state_q == BUSY);
    done = (state_q == DONE);
  end

  // Write-port mux: the copy owns the port in BUSY (and is suppressed on a
  // reset edge); otherwise the external preload path drives it.
  always_comb begin
    if (state_q == BUSY) begin
      rf_we    = copy_active && !reset;
      rf_waddr = back_q;
      rf_wdata = front_data;
    end else begin
      rf_we    = ext_we;
      rf_waddr = ext_addr;
      rf_wdata = ext_wdata;
    end
  end

  assign copies = copies_q;

  mirror_regfile #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clock     (clock),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata),
    .raddr_a_i (front_q),
    .rdata_a_o (front_data),
    .raddr_b_i (rd_addr),
    .rdata_b_o (rd_data)
  );

endmodule

// File: tb/tb_palindrome_mirror.sv
// Self-checking bench for palindrome_mirror: a memory model plus a scoreboard
// of expected run results consumed by an independent done monitor.
module tb_palindrome_mirror;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              go = 1'b0;
  logic [ADDR_W-1:0] base = '0;
  logic [ADDR_W-1:0] ending = '0;
  logic              ext_we = 1'b0;
  logic [ADDR_W-1:0] ext_addr = '0;
  logic [WIDTH-1:0]  ext_wdata = '0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [WIDTH-1:0]  rd_data;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] copies;

  always #5 clock = ~clock;

  palindrome_mirror #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .go        (go),
    .base      (base),
    .ending    (ending),
    .ext_we    (ext_we),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .copies    (copies)
  );

  typedef struct {
    int    n_copies;
    int    done_cyc;
    string tag;
  } exp_t;

  exp_t             sb[$];
  exp_t             mon_e;
  logic [WIDTH-1:0] model [DEPTH];
  int               checks = 0;
  int               failures = 0;
  int               cyc = 0;
  logic             done_prev = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every rising done must match the oldest outstanding run.
  always @(negedge clock) begin
    if (done && !done_prev) begin
      check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check({mon_e.tag, "_copies"},  64'(copies), 64'(mon_e.n_copies));
        check({mon_e.tag, "_latency"}, 64'(cyc),    64'(mon_e.done_cyc));
        check({mon_e.tag, "_busy"},    64'(busy),   64'd0);
      end
    end
    done_prev <= done;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic ext_write(input int addr, input logic [WIDTH-1:0] data);
    ext_we    = 1'b1;
    ext_addr  = ADDR_W'(addr);
    ext_wdata = data;
    tick();
    ext_we = 1'b0;
    model[addr] = data;
  endtask

  function automatic int n_of(input int b, input int e);
    return (e >= b) ? (e - b + 1) / 2 : 0;
  endfunction

  // Reference: mirror the front half onto the back half.
  function automatic void model_mirror(input int b, input int e, input int limit);
    for (int i = 0; i < limit; i++) model[e - i] = model[b + i];
  endfunction

  task automatic dump_check(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = ADDR_W'(i);
      #1;
      check($sformatf("%s_r%0d", tag, i), 64'(rd_data), 64'(model[i]));
    end
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 200 && !done; k++) tick();
    check({tag, "_done_seen"}, 64'(done), 64'd1);
  endtask

  // Start a run; expected outcome goes to the scoreboard before the edge.
  task automatic start_run(input int b, input int e, input string tag);
    int n;
    n = n_of(b, e);
    base   = ADDR_W'(b);
    ending = ADDR_W'(e);
    go     = 1'b1;
    sb.push_back('{n_copies: n, done_cyc: cyc + n + 2, tag: tag});
    model_mirror(b, e, n);
  endtask

  task automatic finish_run(input int b, input int e, input string tag);
    go = 1'b0;
    tick();
    check({tag, "_idle_done"}, 64'(done), 64'd0);
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    check({tag, "_idle_copies"}, 64'(copies), 64'(n_of(b, e)));
    dump_check(tag);
  endtask

  task automatic run(input int b, input int e, input string tag);
    start_run(b, e, tag);
    wait_done(tag);
    finish_run(b, e, tag);
  endtask

  initial begin
    int b, e, nw;
    @(negedge clock);
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_copies", 64'(copies), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) ext_write(i, $urandom());
    dump_check("preload");

    // Even range.
    ext_write(11, 32'h12344321);
    ext_write(12, 32'hAAAA0000);
    ext_write(13, 32'h0);
    ext_write(14, 32'h0);
    run(11, 14, "even");

    // Odd range: middle word untouched.
    ext_write(2, 32'hCAFEBABE);
    ext_write(3, 32'hFFFFFFFF);
    ext_write(4, 32'h0B3D1E55);
    ext_write(5, 32'h0);
    ext_write(6, 32'h0);
    run(2, 6, "odd");

    // Degenerate ranges.
    run(5, 5, "single");
    run(9, 3, "reversed");

    // Full range.
    for (int i = 0; i < DEPTH; i++) ext_write(i, WIDTH'(i));
    run(0, 31, "full");

    // Reset after three copy edges.
    for (int i = 0; i < DEPTH; i++) ext_write(i, WIDTH'(i));
    base = '0; ending = 5'd31; go = 1'b1;
    tick();
    go = 1'b0;
    tick(); tick(); tick();
    check("abort_busy_pre", 64'(busy), 64'd1);
    check("abort_copies_pre", 64'(copies), 64'd3);
    model_mirror(0, 31, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_copies", 64'(copies), 64'd0);
    tick();
    check("abort_stay_idle", 64'(busy), 64'd0);
    dump_check("abort");

    // Hold done with go, external write ignored while busy.
    start_run(16, 23, "hold");
    tick();
    check("hold_busy", 64'(busy), 64'd1);
    ext_we = 1'b1; ext_addr = 5'd20; ext_wdata = 32'hDEADBEEF;
    tick();
    ext_we = 1'b0;
    wait_done("hold");
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("hold_done_%0d", k), 64'(done), 64'd1);
    end
    finish_run(16, 23, "hold");

    // Randomized runs with sparse random preloads.
    for (int r = 0; r < 20; r++) begin
      nw = $urandom_range(0, 4);
      for (int w = 0; w < nw; w++) ext_write($urandom_range(0, DEPTH - 1), $urandom());
      b = $urandom_range(0, DEPTH - 1);
      e = $urandom_range(0, DEPTH - 1);
      run(b, e, $sformatf("rand%0d", r));
    end

    tick(); tick();
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
